// File: rtl/instr_exec_sequencer_pkg.sv
// Shared types for the instruction executor.
//   opcode_t      : 4-bit opcode. Values above MOD are illegal and executed as errors.
//   operand_t     : signed OP_W operand.
//   result_t      : signed RES_W result.
//   instruction_t : {opc, op_a, op_b} word held in the instruction register.
//   exec_state_t  : sequencer FSM states.
package instr_exec_sequencer_pkg;

  localparam int OP_W  = 32;
  localparam int RES_W = 64;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [OP_W-1:0]  operand_t;
  typedef logic signed [RES_W-1:0] result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } exec_state_t;

  // Sign-extend an operand to the full result width.
  function automatic result_t sext(input operand_t v);
    return {{(RES_W-OP_W){v[OP_W-1]}}, v};
  endfunction

endpackage

// File: rtl/instr_exec_sequencer_if.sv
// Result stream between the executor (master) and its consumer (slave).
//   res_valid  : master -> slave, result offered
//   res_ready  : slave -> master, result accepted
//   res_addr   : location the result belongs to
//   res_opcode : opcode executed
//   res_data   : signed result
//   res_err    : divide/mod by zero or illegal opcode
interface instr_exec_sequencer_if #(
  parameter int ADDR_W = 5
);
  import instr_exec_sequencer_pkg::*;

  logic              res_valid;
  logic              res_ready;
  logic [ADDR_W-1:0] res_addr;
  opcode_t           res_opcode;
  result_t           res_data;
  logic              res_err;

  modport master (
    output res_valid, res_addr, res_opcode, res_data, res_err,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_addr, res_opcode, res_data, res_err,
    output res_ready
  );

endinterface

// File: rtl/instr_alu.sv
// Purely combinational opcode evaluator.
//   opcode, op_a, op_b : instruction fields
//   res_data           : signed RES_W result (0 on error)
//   res_err            : divide/mod by zero or opcode outside the enum
module instr_alu
  import instr_exec_sequencer_pkg::*;
(
  input  opcode_t  opcode,
  input  operand_t op_a,
  input  operand_t op_b,
  output result_t  res_data,
  output logic     res_err
);

  result_t a_ext;
  result_t b_ext;

  assign a_ext = sext(op_a);
  assign b_ext = sext(op_b);

  // Operating at RES_W makes MULT exact and keeps DIV of the most negative
  // operand by -1 from overflowing. SV signed '/' truncates toward zero and
  // '%' takes the sign of the dividend, which is the required semantics.
  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    case (opcode)
      ZERO:  res_data = '0;
      PASSA: res_data = a_ext;
      PASSB: res_data = b_ext;
      ADD:   res_data = a_ext + b_ext;
      SUB:   res_data = a_ext - b_ext;
      MULT:  res_data = a_ext * b_ext;
      DIV: begin
        if (b_ext == '0) res_err  = 1'b1;
        else             res_data = a_ext / b_ext;
      end
      MOD: begin
        if (b_ext == '0) res_err  = 1'b1;
        else             res_data = a_ext % b_ext;
      end
      default: res_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_exec_sequencer.sv
// Walks num_instr instruction-register locations from start_addr (wrapping),
// executes each instruction and offers the result on a valid/ready stream.
//   clk, reset_n         : clock, asynchronous active-low reset
//   start, start_addr,
//   num_instr            : run request (sampled in IDLE only)
//   busy, done           : not-IDLE flag, one-cycle end-of-run pulse
//   read_pointer         : registered address to the instruction register
//   instruction_word     : combinational read data for read_pointer
//   res_if (master)      : result stream
// Optional build macro INSTR_EXEC_STATS_EN adds exec_count / err_count,
// saturating handshake counters cleared on reset and on an accepted start.
module instr_exec_sequencer
  import instr_exec_sequencer_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      start_addr,
  input  logic [ADDR_W:0]        num_instr,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      read_pointer,
  input  instruction_t           instruction_word,
  instr_exec_sequencer_if.master res_if
`ifdef INSTR_EXEC_STATS_EN
  ,
  output logic [15:0]            exec_count,
  output logic [15:0]            err_count
`endif
);

  exec_state_t    state_reg;
  exec_state_t    state_next;
  logic [ADDR_W:0] cnt_reg;
  instruction_t   iw_q;
  result_t        alu_data;
  logic           alu_err;
  logic           handshake;
  logic           last_instr;

  assign handshake  = res_if.res_valid && res_if.res_ready;
  assign last_instr = (cnt_reg == (ADDR_W+1)'(1));
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DONE);

  instr_alu u_alu (
    .opcode   (iw_q.opc),
    .op_a     (iw_q.op_a),
    .op_b     (iw_q.op_b),
    .res_data (alu_data),
    .res_err  (alu_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (num_instr == '0) ? DONE : FETCH;
      end
      FETCH: state_next = EXEC;
      EXEC:  state_next = OUT;
      OUT: begin
        if (handshake) state_next = last_instr ? DONE : FETCH;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers. Result fields are written only in EXEC, so they stay
  // stable for the whole time the consumer stalls in OUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_pointer      <= '0;
      cnt_reg           <= '0;
      iw_q              <= '0;
      res_if.res_valid  <= 1'b0;
      res_if.res_addr   <= '0;
      res_if.res_opcode <= ZERO;
      res_if.res_data   <= '0;
      res_if.res_err    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            read_pointer <= start_addr;
            cnt_reg      <= num_instr;
          end
        end
        FETCH: iw_q <= instruction_word;
        EXEC: begin
          res_if.res_addr   <= read_pointer;
          res_if.res_opcode <= iw_q.opc;
          res_if.res_data   <= alu_data;
          res_if.res_err    <= alu_err;
          res_if.res_valid  <= 1'b1;
        end
        OUT: begin
          if (handshake) begin
            res_if.res_valid <= 1'b0;
            cnt_reg          <= cnt_reg - (ADDR_W+1)'(1);
            // Pointer stays on the last location when the run ends.
            if (!last_instr) read_pointer <= read_pointer + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef INSTR_EXEC_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exec_count <= '0;
      err_count  <= '0;
    end else if (state_reg == IDLE && start) begin
      exec_count <= '0;
      err_count  <= '0;
    end else if (state_reg == OUT && handshake) begin
      if (exec_count != 16'hFFFF) exec_count <= exec_count + 16'd1;
      if (res_if.res_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_exec_sequencer.sv
module tb_instr_exec_sequencer;
  import instr_exec_sequencer_pkg::*;

  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W:0]   num_instr = '0;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] read_pointer;
  instruction_t      instruction_word;
  instruction_t      mem [32];
`ifdef INSTR_EXEC_STATS_EN
  logic [15:0]       exec_count;
  logic [15:0]       err_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  instr_exec_sequencer_if #(.ADDR_W(ADDR_W)) res_if ();

  instr_exec_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .start_addr       (start_addr),
    .num_instr        (num_instr),
    .busy             (busy),
    .done             (done),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .res_if           (res_if)
`ifdef INSTR_EXEC_STATS_EN
    ,
    .exec_count       (exec_count),
    .err_count        (err_count)
`endif
  );

  always #5 clk = ~clk;

  assign instruction_word = mem[read_pointer];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] n);
    @(negedge clk);
    start = 1'b1; start_addr = a; num_instr = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (res_if.res_valid !== 1'b1) begin
      if (cyc >= 40) begin cyc = -1; return; end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy !== 1'b0 && c < 60) begin @(negedge clk); c++; end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({busy, done, res_if.res_valid, res_if.res_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: busy/done/valid/err=%b required 0000",
                         {busy, done, res_if.res_valid, res_if.res_err});
    end
    n_tests++;
    if (read_pointer !== '0 || res_if.res_addr !== '0 || res_if.res_data !== '0 ||
        res_if.res_opcode !== ZERO) begin
      n_fail++; $display("FAIL reset_regs: rp=%0d addr=%0d data=%0d opc=%0d required all 0",
                         read_pointer, res_if.res_addr, res_if.res_data, res_if.res_opcode);
    end
  endtask

  task automatic test_add();
    result_t e;
    mem[3].opc = ADD; mem[3].op_a = -7; mem[3].op_b = 5;
    e = -2;
    res_if.res_ready = 1'b1;
    pulse_start(5'd3, 6'd1);
    n_tests++;
    if (res_if.res_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL add_c1: valid=%b busy=%b required 0 1", res_if.res_valid, busy);
    end
    @(negedge clk);
    n_tests++;
    if (res_if.res_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_c2_valid: got %b required 0", res_if.res_valid);
    end
    @(negedge clk);
    $display("[TB] add: addr=%0d data=%0d err=%b", res_if.res_addr, res_if.res_data, res_if.res_err);
    n_tests++;
    if (res_if.res_valid !== 1'b1 || res_if.res_addr !== 5'd3 || res_if.res_opcode !== ADD) begin
      n_fail++; $display("FAIL add_c3: valid=%b addr=%0d opc=%0d required 1 3 %0d",
                         res_if.res_valid, res_if.res_addr, res_if.res_opcode, ADD);
    end
    n_tests++;
    if (res_if.res_data !== e || res_if.res_err !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL add_data: data=%0d err=%b done=%b required %0d 0 0",
                         res_if.res_data, res_if.res_err, done, e);
    end
    @(negedge clk);
    n_tests++;
    if (res_if.res_valid !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL add_done: valid=%b done=%b required 0 1", res_if.res_valid, done);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL add_end: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_opcodes();
    opcode_t ops [11];
    int      as  [11];
    int      bs  [11];
    longint  ed  [11];
    bit      ee  [11];
    int      cyc;
    int      dbase;
    result_t e;
    ops = '{PASSA, PASSB, SUB, MULT, DIV, MOD, ADD, ZERO, DIV, MOD, opcode_t'(4'hB)};
    as  = '{-15, -15, -15, -15, -15, -15, -15, -15, 9, -15, 1};
    bs  = '{4, 4, 4, 4, 4, 4, 4, 4, 0, 0, 1};
    ed  = '{-15, 4, -19, -60, -3, -3, -11, 0, 0, 0, 0};
    ee  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 11; i++) begin
      mem[8+i].opc = ops[i]; mem[8+i].op_a = as[i]; mem[8+i].op_b = bs[i];
    end
    res_if.res_ready = 1'b1;
    dbase = done_cnt;
    pulse_start(5'd8, 6'd11);
    for (int i = 0; i < 11; i++) begin
      wait_valid(cyc);
      n_tests++;
      if (cyc < 0) begin
        n_fail++; $display("FAIL op_timeout[%0d]: no res_valid required 1", i);
        break;
      end
      e = ed[i];
      $display("[TB] op %0d: addr=%0d data=%0d err=%b", i, res_if.res_addr, res_if.res_data, res_if.res_err);
      if (res_if.res_addr !== 5'(8+i) || res_if.res_data !== e || res_if.res_err !== ee[i]) begin
        n_fail++; $display("FAIL op[%0d]: addr=%0d data=%0d err=%b required %0d %0d %b",
                           i, res_if.res_addr, res_if.res_data, res_if.res_err, 8+i, e, ee[i]);
      end
      @(negedge clk);
    end
    wait_idle();
    n_tests++;
    if (done_cnt - dbase != 1) begin
      n_fail++; $display("FAIL op_done_count: got %0d required 1", done_cnt - dbase);
    end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_addr [4];
    int      cyc;
    int      dbase;
    result_t e;
    exp_addr = '{5'd30, 5'd31, 5'd0, 5'd1};
    for (int k = 0; k < 4; k++) begin
      mem[exp_addr[k]].opc = PASSB; mem[exp_addr[k]].op_a = 0; mem[exp_addr[k]].op_b = 200 + k;
    end
    res_if.res_ready = 1'b1;
    dbase = done_cnt;
    pulse_start(5'd30, 6'd4);
    for (int k = 0; k < 4; k++) begin
      wait_valid(cyc);
      n_tests++;
      if (cyc < 0) begin
        n_fail++; $display("FAIL wrap_timeout[%0d]: no res_valid required 1", k);
        break;
      end
      e = 200 + k;
      $display("[TB] wrap %0d: addr=%0d data=%0d", k, res_if.res_addr, res_if.res_data);
      if (res_if.res_addr !== exp_addr[k] || res_if.res_data !== e) begin
        n_fail++; $display("FAIL wrap[%0d]: addr=%0d data=%0d required %0d %0d",
                           k, res_if.res_addr, res_if.res_data, exp_addr[k], e);
      end
      if (k > 0) begin
        n_tests++;
        if (cyc + 1 != 3) begin
          n_fail++; $display("FAIL wrap_gap[%0d]: got %0d cycles required 3", k, cyc + 1);
        end
      end
      @(negedge clk);
    end
    wait_idle();
    n_tests++;
    if (done_cnt - dbase != 1) begin
      n_fail++; $display("FAIL wrap_done_count: got %0d required 1", done_cnt - dbase);
    end
  endtask

  task automatic test_backpressure();
    int      cyc;
    int      dbase;
    result_t e1;
    result_t e2;
    mem[5].opc = SUB; mem[5].op_a = 10; mem[5].op_b = 3;
    mem[6].opc = ADD; mem[6].op_a = 1;  mem[6].op_b = 1;
    mem[20].opc = PASSA; mem[20].op_a = 77; mem[20].op_b = 0;
    e1 = 7; e2 = 2;
    res_if.res_ready = 1'b0;
    dbase = done_cnt;
    pulse_start(5'd5, 6'd2);
    wait_valid(cyc);
    n_tests++;
    if (cyc < 0) begin
      n_fail++; $display("FAIL bp_timeout: no res_valid required 1");
    end
    for (int h = 0; h < 5; h++) begin
      n_tests++;
      if (res_if.res_valid !== 1'b1 || res_if.res_addr !== 5'd5 || res_if.res_data !== e1 ||
          read_pointer !== 5'd5 || busy !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: valid=%b addr=%0d data=%0d rp=%0d busy=%b required 1 5 %0d 5 1",
                           h, res_if.res_valid, res_if.res_addr, res_if.res_data, read_pointer, busy, e1);
      end
      if (h == 1) begin start = 1'b1; start_addr = 5'd20; num_instr = 6'd1; end
      if (h == 2) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    $display("[TB] bp: released addr=%0d data=%0d", res_if.res_addr, res_if.res_data);
    res_if.res_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (res_if.res_valid !== 1'b0 || read_pointer !== 5'd6) begin
      n_fail++; $display("FAIL bp_accept: valid=%b rp=%0d required 0 6", res_if.res_valid, read_pointer);
    end
    wait_valid(cyc);
    $display("[TB] bp: second addr=%0d data=%0d", res_if.res_addr, res_if.res_data);
    n_tests++;
    if (cyc < 0 || res_if.res_addr !== 5'd6 || res_if.res_data !== e2) begin
      n_fail++; $display("FAIL bp_second: addr=%0d data=%0d required 6 %0d",
                         res_if.res_addr, res_if.res_data, e2);
    end
    @(negedge clk);
    wait_idle();
    n_tests++;
    if (done_cnt - dbase != 1) begin
      n_fail++; $display("FAIL bp_done_count: got %0d required 1", done_cnt - dbase);
    end
  endtask

  task automatic test_zero_len();
    res_if.res_ready = 1'b1;
    pulse_start(5'd4, 6'd0);
    $display("[TB] zero_len: done=%b valid=%b", done, res_if.res_valid);
    n_tests++;
    if (done !== 1'b1 || res_if.res_valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: done=%b valid=%b required 1 0", done, res_if.res_valid);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || res_if.res_valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_end: done=%b busy=%b valid=%b required 0 0 0",
                         done, busy, res_if.res_valid);
    end
  endtask

`ifdef INSTR_EXEC_STATS_EN
  task automatic test_stats();
    int cyc;
    mem[20].opc = ADD;  mem[20].op_a = 1; mem[20].op_b = 2;
    mem[21].opc = DIV;  mem[21].op_a = 9; mem[21].op_b = 0;
    mem[22].opc = SUB;  mem[22].op_a = 5; mem[22].op_b = 1;
    mem[23].opc = MULT; mem[23].op_a = 3; mem[23].op_b = 3;
    res_if.res_ready = 1'b1;
    pulse_start(5'd20, 6'd4);
    for (int k = 0; k < 4; k++) begin
      wait_valid(cyc);
      if (cyc < 0) break;
      @(negedge clk);
    end
    wait_idle();
    $display("[TB] stats: exec=%0d err=%0d", exec_count, err_count);
    n_tests++;
    if (exec_count !== 16'd4 || err_count !== 16'd1) begin
      n_fail++; $display("FAIL stats_counts: exec=%0d err=%0d required 4 1", exec_count, err_count);
    end
    pulse_start(5'd0, 6'd0);
    n_tests++;
    if (exec_count !== 16'd0 || err_count !== 16'd0) begin
      n_fail++; $display("FAIL stats_clear: exec=%0d err=%0d required 0 0", exec_count, err_count);
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_async_reset();
    int cyc;
    res_if.res_ready = 1'b0;
    pulse_start(5'd3, 6'd1);
    wait_valid(cyc);
    n_tests++;
    if (cyc < 0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL arst_setup: valid wait=%0d busy=%b required OUT state", cyc, busy);
    end
    #2 reset_n = 1'b0;
    #1;
    $display("[TB] async reset: busy=%b valid=%b", busy, res_if.res_valid);
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || res_if.res_valid !== 1'b0) begin
      n_fail++; $display("FAIL arst_after: busy=%b valid=%b required 0 0", busy, res_if.res_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    res_if.res_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_add();
    test_opcodes();
    test_wrap();
    test_backpressure();
    test_zero_len();
`ifdef INSTR_EXEC_STATS_EN
    test_stats();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
